// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle RV32M multiply/divide unit for the Execute stage. A single-clock
// iterative datapath: a shift-add multiplier retiring MUL_STEP multiplier bits
// per cycle, and a restoring divider retiring one quotient bit per cycle.
//
// Operation: start is sampled in IDLE or DONE. The operands are converted to
// magnitudes plus sign bits. The unit iterates in MUL or DIV, then spends one
// cycle in FIXUP, where it applies the signs, handles the architectural
// corner cases and registers the result. done pulses for one cycle in DONE.
// The result is held until the next accepted operation.
//
// Parameters:
//   DATA_WIDTH : operand/result width (even, >= 8)
//   MUL_STEP   : multiplier bits per cycle (1, 2 or 4, divides DATA_WIDTH)
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, the following ops jump directly from accept to FIXUP, so
//   done arrives two edges after accept:
//     - divide-by-zero;
//     - signed overflow (most-negative / -1);
//     - multiply with a zero operand.
//   When undefined, every op takes the full iterative latency.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (sampled in IDLE/DONE only)
//   flush  in   synchronous abort; wins over start
//   op     in   funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   opA    in   rs1 value
//   opB    in   rs2 value
//   busy   out  operation in flight
//   stall  out  copy of busy for the Execute/Memory register
//   done   out  one-cycle pulse when result becomes valid
//   result out  result word, held until the next accepted start
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STEP   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    output logic                  busy,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W         = DATA_WIDTH;
    localparam int MUL_ITERS = DATA_WIDTH / MUL_STEP;
    localparam int CNT_W     = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Two's-complement negate when en is set (single word).
    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic en);
        logic [W-1:0] r;
        if (en) begin
            r = ~v + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negate when en is set (double word).
    function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic en);
        logic [2*W-1:0] r;
        if (en) begin
            r = ~v + {{(2*W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t               state_r;
    logic [2:0]           op_r;
    logic                 sign_a_r;
    logic                 sign_b_r;
    logic [W-1:0]         a_mag_r;
    logic [W-1:0]         b_mag_r;
    logic [2*W-1:0]       acc_r;
    logic [W-1:0]         quo_r;     // multiplier shifter in MUL, dividend/quotient in DIV
    logic [W-1:0]         rem_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic [W-1:0]         result_r;

    logic                 a_signed_s;
    logic                 b_signed_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [W-1:0]         mag_a_s;
    logic [W-1:0]         mag_b_s;
    logic                 early_s;
    state_t               accept_state_s;

    logic [W+MUL_STEP-1:0] partial_s;
    logic [W+MUL_STEP-1:0] hi_sum_s;
    logic [2*W-1:0]        acc_next_s;

    logic [W:0]           shifted_s;
    logic                 div_ge_s;
    logic [W-1:0]         rem_sub_s;

    logic                 div_zero_s;
    logic [2*W-1:0]       prod_s;
    logic [W-1:0]         quo_fix_s;
    logic [W-1:0]         rem_fix_s;
    logic [W-1:0]         result_fix_s;

    assign busy   = busy_r;
    assign stall  = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Operand signedness per funct3 and conversion to sign + magnitude.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op)
            3'b001:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end  // MULH
            3'b010:  begin a_signed_s = 1'b1; b_signed_s = 1'b0; end  // MULHSU
            3'b100:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end  // DIV
            3'b110:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end  // REM
            default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        sign_a_s = a_signed_s & opA[W-1];
        sign_b_s = b_signed_s & opB[W-1];
        mag_a_s  = cond_neg(opA, sign_a_s);
        mag_b_s  = cond_neg(opB, sign_b_s);
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Detect operations whose result needs no iteration.
    always_comb begin
        early_s = 1'b0;
        if (op[2]) begin
            early_s = (opB == {W{1'b0}}) |
                      (~op[0] & (opA == {1'b1, {(W-1){1'b0}}}) & (opB == {W{1'b1}}));
        end else begin
            early_s = (opA == {W{1'b0}}) | (opB == {W{1'b0}});
        end
    end
`else
    assign early_s = 1'b0;
`endif

    // State entered on accept.
    always_comb begin
        accept_state_s = S_MUL;
        if (early_s) begin
            accept_state_s = S_FIXUP;
        end else if (op[2]) begin
            accept_state_s = S_DIV;
        end else begin
            accept_state_s = S_MUL;
        end
    end

    // One multiply step: add a_mag * next multiplier digit into the upper half,
    // then shift the whole accumulator right so finished product bits move down.
    always_comb begin
        partial_s  = {{MUL_STEP{1'b0}}, a_mag_r} * {{W{1'b0}}, quo_r[MUL_STEP-1:0]};
        hi_sum_s   = {{MUL_STEP{1'b0}}, acc_r[2*W-1:W]} + partial_s;
        acc_next_s = {hi_sum_s, acc_r[W-1:MUL_STEP]};
    end

    // One restoring-division step: shift in the next dividend bit and try a subtract.
    always_comb begin
        shifted_s = {rem_r, quo_r[W-1]};
        div_ge_s  = (shifted_s >= {1'b0, b_mag_r});
        rem_sub_s = shifted_s[W-1:0] - b_mag_r;
    end

    // Sign correction, divide-by-zero forcing and result word selection.
    // Overflow (most-negative / -1) needs no forcing: the magnitude 2^(W-1)
    // negates onto itself and the remainder is already zero.
    always_comb begin
        div_zero_s = (b_mag_r == {W{1'b0}});
        prod_s     = cond_neg2(acc_r, sign_a_r ^ sign_b_r);
        if (div_zero_s) begin
            quo_fix_s = {W{1'b1}};
        end else begin
            quo_fix_s = cond_neg(quo_r, sign_a_r ^ sign_b_r);
        end
        rem_fix_s = cond_neg(div_zero_s ? a_mag_r : rem_r, sign_a_r);
        case (op_r)
            3'b000:  result_fix_s = prod_s[W-1:0];
            3'b001:  result_fix_s = prod_s[2*W-1:W];
            3'b010:  result_fix_s = prod_s[2*W-1:W];
            3'b011:  result_fix_s = prod_s[2*W-1:W];
            3'b100:  result_fix_s = quo_fix_s;
            3'b101:  result_fix_s = quo_fix_s;
            3'b110:  result_fix_s = rem_fix_s;
            3'b111:  result_fix_s = rem_fix_s;
            default: result_fix_s = {W{1'b0}};
        endcase
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            op_r     <= 3'b000;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            a_mag_r  <= {W{1'b0}};
            b_mag_r  <= {W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            quo_r    <= {W{1'b0}};
            rem_r    <= {W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {W{1'b0}};
        end else if (flush) begin
            // Abort: drop any operation in flight, keep the last result.
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r     <= op;
                        sign_a_r <= sign_a_s;
                        sign_b_r <= sign_b_s;
                        a_mag_r  <= mag_a_s;
                        b_mag_r  <= mag_b_s;
                        acc_r    <= {(2*W){1'b0}};
                        rem_r    <= {W{1'b0}};
                        quo_r    <= op[2] ? mag_a_s : mag_b_s;
                        cnt_r    <= op[2] ? CNT_W'(W - 1) : CNT_W'(MUL_ITERS - 1);
                        state_r  <= accept_state_s;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc_r <= acc_next_s;
                    quo_r <= quo_r >> MUL_STEP;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= S_FIXUP;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DIV: begin
                    quo_r <= {quo_r[W-2:0], div_ge_s};
                    rem_r <= div_ge_s ? rem_sub_s : shifted_s[W-1:0];
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= S_FIXUP;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_FIXUP: begin
                    result_r <= result_fix_s;
                    state_r  <= S_DONE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (DATA_WIDTH=32, MUL_STEP=2). Expected
// results are pushed to a scoreboard queue when an operation is issued and
// popped when done is seen. Latency expectations follow MULDIV_EARLY_OUT_EN.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SHORT = 2;
`else
    localparam int LAT_SHORT = 34;
`endif
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_MULZ = 2;
`else
    localparam int LAT_MULZ = 18;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32), .MUL_STEP(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .opA(opA), .opB(opB), .busy(busy), .stall(stall), .done(done), .result(result)
    );

    // Reference model of the RV32M operations.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 32'd0) return a; return a % b; end
        endcase
    endfunction

    // Drive one start cycle (caller is #1 after an edge, DUT in IDLE/DONE).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        op = o; opA = a; opB = b; start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        start = 1'b0;
        opA = $urandom; opB = $urandom; op = 3'($urandom_range(0, 7));
    endtask

    // Wait for done (bounded); lat counts edges with the accept edge as 1.
    task automatic wait_done(output int lat, output int busy_cycles, output logic [31:0] res, output bit timed_out);
        lat = 1; busy_cycles = 0; timed_out = 1'b1; res = 32'd0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                res = result;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        bit          saw_done;
        rst_n = 1'b0; start = 1'b1; flush = 1'b0; op = 3'd0; opA = 32'd5; opB = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Reset in the middle of an operation discards it.
        issue(3'd0, 32'd9, 32'd9, 32'd81);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
        void'(exp_q.pop_back());
        rst_n = 1'b1;
        @(posedge clk); #1;
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midop_reset_done: got %b expected 0", saw_done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL midop_reset_result: got %h expected 0", result); end
    endtask

    task automatic test_mul();
        vec_t v[4];
        int lat; int bc; logic [31:0] res; bit to; logic [31:0] e;
        v[0] = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 18};
        v[1] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18};
        v[2] = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18};
        v[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18};
        for (int k = 0; k < 4; k++) begin
            issue(v[k].op, v[k].a, v[k].b, v[k].expv);
            n_checks++; if (stall !== busy || busy !== 1'b1) begin n_fail++; $display("FAIL mul_stall[%0d]: busy %b stall %b expected 1 1", k, busy, stall); end
            wait_done(lat, bc, res, to);
            e = exp_q.pop_front();
            n_checks++; if (to) begin n_fail++; $display("FAIL mul_timeout[%0d]: done not seen", k); end
            n_checks++; if (res !== e) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", k, res, e); end
            n_checks++; if (lat !== v[k].lat) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", k, lat, v[k].lat); end
            n_checks++; if (bc !== v[k].lat - 1) begin n_fail++; $display("FAIL mul_busy_cycles[%0d]: got %0d expected %0d", k, bc, v[k].lat - 1); end
            @(posedge clk); #1;
            n_checks++; if (done !== 1'b0 || result !== e) begin n_fail++; $display("FAIL mul_hold[%0d]: done %b result %h expected 0 %h", k, done, result, e); end
        end
    endtask

    task automatic test_div();
        vec_t v[3];
        int lat; int bc; logic [31:0] res; bit to; logic [31:0] e;
        v[0] = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34};
        v[1] = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34};
        v[2] = '{3'd5, 32'd100,       32'd7, 32'd14,        34};
        for (int k = 0; k < 3; k++) begin
            issue(v[k].op, v[k].a, v[k].b, v[k].expv);
            wait_done(lat, bc, res, to);
            e = exp_q.pop_front();
            n_checks++; if (to) begin n_fail++; $display("FAIL div_timeout[%0d]: done not seen", k); end
            n_checks++; if (res !== e) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", k, res, e); end
            n_checks++; if (lat !== v[k].lat) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected %0d", k, lat, v[k].lat); end
            n_checks++; if (bc !== v[k].lat - 1) begin n_fail++; $display("FAIL div_busy_cycles[%0d]: got %0d expected %0d", k, bc, v[k].lat - 1); end
        end
    endtask

    task automatic test_corner();
        vec_t v[6];
        int lat; int bc; logic [31:0] res; bit to; logic [31:0] e;
        v[0] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SHORT};
        v[1] = '{3'd6, 32'd5,         32'd0,         32'd5,         LAT_SHORT};
        v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SHORT};
        v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SHORT};
        v[4] = '{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, LAT_SHORT};
        v[5] = '{3'd1, 32'd0,         32'h1234_5678, 32'd0,         LAT_MULZ};
        for (int k = 0; k < 6; k++) begin
            issue(v[k].op, v[k].a, v[k].b, v[k].expv);
            wait_done(lat, bc, res, to);
            e = exp_q.pop_front();
            n_checks++; if (to) begin n_fail++; $display("FAIL corner_timeout[%0d]: done not seen", k); end
            n_checks++; if (res !== e) begin n_fail++; $display("FAIL corner_result[%0d]: got %h expected %h", k, res, e); end
            n_checks++; if (lat !== v[k].lat) begin n_fail++; $display("FAIL corner_latency[%0d]: got %0d expected %0d", k, lat, v[k].lat); end
        end
    endtask

    task automatic test_random();
        int lat; int bc; logic [31:0] res; bit to; logic [31:0] e;
        logic [2:0] o; logic [31:0] a; logic [31:0] b;
        for (int k = 0; k < 16; k++) begin
            o = 3'(k % 8);
            a = $urandom;
            b = (k == 13 || k == 14) ? 32'd0 : 32'($urandom) >> (k % 24);
            issue(o, a, b, model(o, a, b));
            wait_done(lat, bc, res, to);
            e = exp_q.pop_front();
            n_checks++; if (to || res !== e) begin n_fail++; $display("FAIL random[%0d] op %0d a %h b %h: got %h expected %h timeout %b", k, o, a, b, res, e, to); end
        end
    endtask

    task automatic test_flush();
        int lat; int bc; logic [31:0] res; bit to; logic [31:0] e;
        bit saw_done; bit saw_busy;
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        wait_done(lat, bc, res, to);
        e = exp_q.pop_front();
        n_checks++; if (to || res !== e) begin n_fail++; $display("FAIL flush_prev: got %h expected %h", res, e); end
        @(posedge clk); #1;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        void'(exp_q.pop_back());
        repeat (8) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b1; op = 3'd0; opA = 32'd3; opB = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle: busy %b stall %b expected 0 0", busy, stall); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result: got %h expected 0000000e", result); end
        saw_done = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            if (busy === 1'b1) saw_busy = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", saw_done); end
        n_checks++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_ignored: got %b expected 0", saw_busy); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result_hold: got %h expected 0000000e", result); end
    endtask

    task automatic test_back_to_back();
        int lat; int bc; logic [31:0] res; bit to; logic [31:0] e;
        issue(3'd0, 32'd3, 32'd4, 32'd12);
        wait_done(lat, bc, res, to);
        e = exp_q.pop_front();
        n_checks++; if (to || res !== e) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", res, e); end
        // Still in DONE: hold start high with the next operation.
        op = 3'd5; opA = 32'd12; opB = 32'd4; start = 1'b1;
        exp_q.push_back(32'd3);
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_no_gap: busy %b done %b expected 1 0", busy, done); end
        // Start pulses while busy are ignored.
        op = 3'd0; opA = 32'd99; opB = 32'd99; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc, res, to);
        e = exp_q.pop_front();
        n_checks++; if (to || res !== e) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", res, e); end
        n_checks++; if (lat + 3 !== 34) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 34", lat + 3); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: done %b busy %b expected 0 0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_corner();
        test_random();
        test_flush();
        test_back_to_back();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d entries left expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
